osd_mam_ahb3_slave_if: RTL

AHB3 slave (responder) that terminates the bus driven by the MAM AHB3 master and converts each accepted beat into a single-beat request on a simple valid/ready memory port. It is the target-side counterpart used to attach on-chip SRAM or register banks, and the MAM loopback test system, to the MAM debug path. Bursts are handled beat by beat, using the per-beat address supplied by the master.

---
 rtl/osd_mam_ahb3_slave_if.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/osd_mam_ahb3_slave_if.sv
// AHB3 responder that turns each accepted AHB beat into one single-beat request
// on a valid/ready memory port; bursts are handled beat by beat.
module osd_mam_ahb3_slave_if #(
  parameter int XLEN = 32,
  parameter int PLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ahb3_hsel_i,
  input  logic [PLEN-1:0] ahb3_haddr_i,
  input  logic [XLEN-1:0] ahb3_hwdata_i,
  input  logic            ahb3_hwrite_i,
  input  logic [2:0]      ahb3_hsize_i,
  input  logic [2:0]      ahb3_hburst_i,
  input  logic [3:0]      ahb3_hprot_i,
  input  logic [1:0]      ahb3_htrans_i,
  input  logic            ahb3_hmastlock_i,
  input  logic            ahb3_hready_i,
  output logic [XLEN-1:0] ahb3_hrdata_o,
  output logic            ahb3_hreadyout_o,
  output logic            ahb3_hresp_o,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [PLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic            mem_rdata_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = XLEN / 8;
  localparam int AW = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [2:0] LSW = 3'($clog2(SW));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_READ_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          r_state, w_state_n, w_dispatch;
  logic [PLEN-1:0] r_addr;
  logic            r_we;
  logic [SW-1:0]   r_be;
  logic [XLEN-1:0] r_hrdata;

  logic            w_accept, w_load, w_take, w_illegal;
  logic            w_hreadyout, w_hresp, w_req_valid;
  logic [AW-1:0]   w_off;
  logic            w_unused;

  // Contiguous little-endian lane mask of 2^size bytes starting at lane off.
  function automatic logic [SW-1:0] f_be(input logic [2:0] size, input logic [AW-1:0] off);
    logic [SW-1:0] m;
    m = '0;
    for (int i = 0; i < SW; i++) begin
      if (32'(i) < (32'd1 << size)) m[i] = 1'b1;
    end
    return m << off;
  endfunction

  assign w_unused   = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i};
  assign w_accept   = ahb3_hsel_i & ahb3_htrans_i[1] & ahb3_hready_i;
  assign w_off      = ahb3_haddr_i[AW-1:0] & AW'(SW - 1);
  assign w_illegal  = (ahb3_hsize_i > LSW) ||
                      ((w_off & AW'((32'd1 << ahb3_hsize_i) - 32'd1)) != '0);
  assign w_dispatch = w_illegal ? S_ERR1 : (ahb3_hwrite_i ? S_WRITE : S_READ_REQ);

  // Address phase is only taken in states where this slave is driving HREADYOUT high.
  always_comb begin
    w_state_n   = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    w_req_valid = 1'b0;
    w_load      = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n = w_dispatch;
          w_load    = 1'b1;
        end
      end
      S_WRITE: begin
        w_req_valid = 1'b1;
        w_hreadyout = mem_req_ready;
        if (mem_req_ready) begin
          w_state_n = w_accept ? w_dispatch : S_IDLE;
          w_load    = w_accept;
        end
      end
      S_READ_REQ: begin
        w_req_valid = 1'b1;
        w_hreadyout = 1'b0;
        if (mem_req_ready) w_state_n = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        w_hreadyout = 1'b0;
        if (mem_rdata_valid) begin
          w_state_n = S_READ_DONE;
          w_take    = 1'b1;
        end
      end
      S_READ_DONE, S_ERR2: begin
        w_hresp   = (r_state == S_ERR2);
        w_state_n = w_accept ? w_dispatch : S_IDLE;
        w_load    = w_accept;
      end
      S_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_state_n   = S_ERR2;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_load) begin
        r_addr <= ahb3_haddr_i;
        r_we   <= ahb3_hwrite_i;
        r_be   <= f_be(ahb3_hsize_i, w_off);
      end
      if (w_take) r_hrdata <= mem_rdata;
    end
  end

  assign ahb3_hrdata_o    = r_hrdata;
  assign ahb3_hreadyout_o = w_hreadyout;
  assign ahb3_hresp_o     = w_hresp;
  assign mem_req_valid    = w_req_valid;
  assign mem_we           = w_req_valid & r_we;
  assign mem_addr         = r_addr;
  assign mem_be           = r_be;
  assign mem_wdata        = ahb3_hwdata_i;

endmodule
